// File: rtl/mult_share_arb.sv
// Purpose : shares one sequential M-bit multiplier core between N requesters.
// Latency : accept at T, mul_start at T+1, rsp_valid at T+2+L (L = core latency).
// Backpr. : one multiply in flight; req_ready is withheld outside IDLE, and RESP holds until rsp_ready[g].
//
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   req_valid/req_ready      - per-requester request handshake (req_ready is a one-hot pulse)
//   req_a, req_b             - packed operands, requester i uses bits [i*M +: M]
//   rsp_valid/rsp_ready      - per-requester response handshake (rsp_valid is one-hot)
//   rsp_p                    - shared 2*M-bit product bus
//   mul_start/mul_a/mul_b    - command to the multiplier core
//   mul_done/mul_p           - result from the multiplier core
//   busy, grant_id           - status: not IDLE, index of current/most recent grant
//
// Build option: define MULT_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority (lowest index wins) and no last-grant pointer exists.

module mult_share_arb #(
    parameter int M = 12,
    parameter int N = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req_valid,
    input  logic [N*M-1:0]         req_a,
    input  logic [N*M-1:0]         req_b,
    output logic [N-1:0]           req_ready,
    output logic [N-1:0]           rsp_valid,
    input  logic [N-1:0]           rsp_ready,
    output logic [2*M-1:0]         rsp_p,
    output logic                   mul_start,
    output logic [M-1:0]           mul_a,
    output logic [M-1:0]           mul_b,
    input  logic                   mul_done,
    input  logic [2*M-1:0]         mul_p,
    output logic                   busy,
    output logic [$clog2(N)-1:0]   grant_id
);

    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [M-1:0]    win_a;
    logic [M-1:0]    win_b;
    logic            accept;
    logic            capture;
    logic            release_rsp;

    // ------------------------------------------------------------------
    // Arbiter
    // ------------------------------------------------------------------
`ifdef MULT_ARB_RR_EN
    logic [IW-1:0]   last_ptr;
    logic [IW-1:0]   rr_idx;

    // Search starts one past the last grant and wraps, so the most recently
    // served requester has the lowest priority next time.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        rr_idx    = '0;
        for (int k = 1; k <= N; k++) begin
            rr_idx = IW'((int'(last_ptr) + k) % N);
            if (!win_found && req_valid[rr_idx]) begin
                win_found = 1'b1;
                win_idx   = rr_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_ptr <= IW'(N - 1);
        end else if (release_rsp) begin
            last_ptr <= grant_id;
        end
    end
`else
    // Downward scan: the last assignment made is the lowest set index.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_valid[IW'(i)]) begin
                win_found = 1'b1;
                win_idx   = IW'(i);
            end
        end
    end
`endif

    // Operand mux for the winning requester.
    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int i = 0; i < N; i++) begin
            if (win_idx == IW'(i)) begin
                win_a = req_a[i*M +: M];
                win_b = req_b[i*M +: M];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready   = '0;
        rsp_valid   = '0;
        mul_start   = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        release_rsp = 1'b0;
        case (state)
            S_IDLE: begin
                // Gated by rst so every output reads 0 while reset is held.
                if (win_found && !rst) begin
                    req_ready[win_idx] = 1'b1;
                    accept             = 1'b1;
                    state_nxt          = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mul_start = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mul_done) begin
                    capture   = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid[grant_id] = 1'b1;
                if (rsp_ready[grant_id]) begin
                    release_rsp = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a    <= '0;
            mul_b    <= '0;
            grant_id <= '0;
            rsp_p    <= '0;
        end else begin
            if (accept) begin
                mul_a    <= win_a;
                mul_b    <= win_b;
                grant_id <= win_idx;
            end
            if (capture) begin
                rsp_p <= mul_p;
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mult_share_arb.sv
// Bench for mult_share_arb with a behavioural multi-cycle multiplier core
// (latency L) and a fault-injection path for stray mul_done pulses.
module tb_mult_share_arb;

    localparam int M = 12;
    localparam int N = 4;
    localparam int L = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req_valid;
    logic [N*M-1:0]     req_a;
    logic [N*M-1:0]     req_b;
    logic [N-1:0]       req_ready;
    logic [N-1:0]       rsp_valid;
    logic [N-1:0]       rsp_ready;
    logic [2*M-1:0]     rsp_p;
    logic               mul_start;
    logic [M-1:0]       mul_a;
    logic [M-1:0]       mul_b;
    logic               mul_done;
    logic [2*M-1:0]     mul_p;
    logic               busy;
    logic [1:0]         grant_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_share_arb #(.M(M), .N(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_p(mul_p),
        .busy(busy), .grant_id(grant_id)
    );

    // Core model: done pulses L cycles after start; product is formed from the
    // operands present at done time, so unstable operands corrupt the result.
    int             cnt;
    logic [M-1:0]   cap_a;
    logic [M-1:0]   cap_b;
    int             stab_err = 0;
    logic           inj_done;
    logic [2*M-1:0] inj_p;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= 0;
            cap_a <= '0;
            cap_b <= '0;
        end else begin
            if (mul_start) begin
                cnt   <= L;
                cap_a <= mul_a;
                cap_b <= mul_b;
            end else if (cnt > 0) begin
                cnt <= cnt - 1;
            end
            if (cnt > 0 && (mul_a !== cap_a || mul_b !== cap_b)) stab_err <= stab_err + 1;
        end
    end

    assign mul_done = (cnt == 1) || inj_done;
    assign mul_p    = inj_done ? inj_p : ({{M{1'b0}}, mul_a} * {{M{1'b0}}, mul_b});

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [M-1:0] a, input logic [M-1:0] b);
        req_a[idx*M +: M] = a;
        req_b[idx*M +: M] = b;
    endtask

    // Returns the index whose req_ready pulsed (-1 on timeout); returns at the
    // negedge following the accepting edge (ISSUE state).
    task automatic wait_grant(output int w);
        w = -1;
        for (int c = 0; c < 60 && w < 0; c++) begin
            #1;
            for (int i = 0; i < N; i++) if (req_ready[i]) w = i;
            @(negedge clk);
        end
    endtask

    // Called one cycle after acceptance; cyc = cycles from acceptance to rsp_valid.
    task automatic wait_rsp(input int idx, output int cyc);
        cyc = -1;
        for (int c = 1; c < 60; c++) begin
            if (rsp_valid[idx]) begin
                cyc = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        int             idx;
        logic [M-1:0]   a;
        logic [M-1:0]   b;
        logic [2*M-1:0] p;
    } vec_t;

    vec_t vecs[7];
    int   exp_seq[5];
    int   w;
    int   cyc;
    bit   hold_ok;

    initial begin
        vecs[0] = '{0, 12'd3,    12'd5,    24'd15};
        vecs[1] = '{1, 12'hFFF,  12'hFFF,  24'hFFE001};
        vecs[2] = '{2, 12'h800,  12'h002,  24'h001000};
        vecs[3] = '{3, 12'h000,  12'hABC,  24'h000000};
        vecs[4] = '{1, 12'h123,  12'h456,  24'h04EDC2};
        vecs[5] = '{2, 12'hFFF,  12'h001,  24'h000FFF};
        vecs[6] = '{0, 12'd100,  12'd200,  24'h004E20};
`ifdef MULT_ARB_RR_EN
        exp_seq = '{0, 1, 2, 3, 0};
`else
        exp_seq = '{0, 0, 0, 0, 0};
`endif

        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = '1;
        inj_done = 1'b0;
        inj_p = '0;
        #1;
        chk("reset_busy",      busy,      0);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_mul_start", mul_start, 0);
        chk("reset_rsp_p",     rsp_p,     0);
        chk("reset_grant_id",  grant_id,  0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single-request vectors.
        foreach (vecs[v]) begin
            set_req(vecs[v].idx, vecs[v].a, vecs[v].b);
            req_valid[vecs[v].idx] = 1'b1;
            wait_grant(w);
            req_valid = '0;
            chk("vec_grant",     w,         vecs[v].idx);
            chk("vec_grant_id",  grant_id,  vecs[v].idx);
            chk("vec_mul_start", mul_start, 1);
            wait_rsp(vecs[v].idx, cyc);
            chk("vec_rsp_valid", rsp_valid, 1 << vecs[v].idx);
            chk("vec_rsp_p",     rsp_p,     vecs[v].p);
            if (v == 0) chk("latency_accept_to_rsp", cyc, 2 + L);
            @(negedge clk);
            chk("vec_back_idle", busy, 0);
        end

        // All four requesting continuously, from a fresh pointer.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 12'(i * 100 + 7), 12'(i * 3 + 11));
        req_valid = '1;
        for (int k = 0; k < 5; k++) begin
            wait_grant(w);
            chk("arb_grant", w, exp_seq[k]);
            if (w >= 0) begin
                wait_rsp(w, cyc);
                chk("arb_rsp_p", rsp_p, (w * 100 + 7) * (w * 3 + 11));
                @(negedge clk);
            end
        end
        req_valid = '0;
        @(negedge clk);

        // Response back-pressure; other rsp_ready bits must be ignored.
        rsp_ready = 4'b1011;
        set_req(2, 12'd7, 12'd9);
        req_valid = 4'b0100;
        wait_grant(w);
        req_valid = '0;
        chk("hold_grant", w, 2);
        wait_rsp(2, cyc);
        set_req(1, 12'd2, 12'd3);
        req_valid = 4'b0011;
        hold_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 5) req_valid[0] = 1'b0;
            #1;
            if (rsp_valid !== 4'b0100 || rsp_p !== 24'd63 || req_ready !== 4'b0000 || busy !== 1'b1)
                hold_ok = 1'b0;
            @(negedge clk);
        end
        chk("hold_stable", hold_ok, 1);
        chk("hold_rsp_p",  rsp_p,   63);
        rsp_ready = '1;
        wait_grant(w);
        req_valid = '0;
        chk("waiter_grant", w, 1);
        wait_rsp(1, cyc);
        chk("waiter_rsp_p", rsp_p, 6);
        @(negedge clk);

        // Reset in WAIT.
        set_req(3, 12'd5, 12'd5);
        req_valid = 4'b1000;
        wait_grant(w);
        req_valid = '0;
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        req_valid = 4'b0010;
        #1;
        chk("rst_busy",      busy,      0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_mul_start", mul_start, 0);
        chk("rst_mul_a",     mul_a,     0);
        chk("rst_mul_b",     mul_b,     0);
        chk("rst_rsp_p",     rsp_p,     0);
        chk("rst_grant_id",  grant_id,  0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        inj_p = 24'h123456;
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        chk("late_done_busy",  busy,  0);
        chk("late_done_rsp_p", rsp_p, 0);
        set_req(0, 12'd21, 12'd4);
        req_valid = '1;
        wait_grant(w);
        req_valid = '0;
        chk("post_rst_grant", w, 0);
        wait_rsp(0, cyc);
        chk("post_rst_rsp_p", rsp_p, 84);
        @(negedge clk);

        // Spurious done in RESP and IDLE.
        rsp_ready = '0;
        set_req(2, 12'hFFF, 12'd2);
        req_valid = 4'b0100;
        wait_grant(w);
        req_valid = '0;
        wait_rsp(2, cyc);
        chk("spur_base_p", rsp_p, 24'h001FFE);
        inj_p = 24'hABCDEF;
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        chk("spur_resp_p",     rsp_p,     24'h001FFE);
        chk("spur_resp_valid", rsp_valid, 4'b0100);
        rsp_ready = '1;
        @(negedge clk);
        chk("spur_pre_idle", busy, 0);
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        chk("spur_idle_busy", busy,  0);
        chk("spur_idle_p",    rsp_p, 24'h001FFE);

        chk("mul_ab_stable", stab_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
